// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the L1/L2 request arbiter
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        RELEASE
    } arb_state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    localparam int DEF_ADDR_W = 26;
    localparam int DEF_LINE_W = 512;

endpackage

// File: rtl/l1_l2_arbiter_if.sv
// rtl/l1_l2_arbiter_if.sv - I-side, D-side and L2-side request/response bundle
interface l1_l2_arbiter_if
    import cache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
);
    logic              read_I_L2;
    logic [ADDR_W-1:0] address_I_L2;
    logic              ready_L2_I;
    logic [LINE_W-1:0] read_data_L2_I;

    logic              read_D_L2;
    logic              write_D_L2;
    logic [ADDR_W-1:0] address_D_L2;
    logic [ADDR_W-1:0] write_address_D_L2;
    logic [LINE_W-1:0] write_data_D_L2;
    logic              ready_L2_D;
    logic [LINE_W-1:0] read_data_L2_D;

    logic              read_L1_L2;
    logic              write_L1_L2;
    logic [ADDR_W-1:0] address_L1_L2;
    logic [ADDR_W-1:0] write_address_L1_L2;
    logic [LINE_W-1:0] write_data_L1_L2;
    logic [LINE_W-1:0] read_data_L2_L1;
    logic              ready_L2_L1;

    // Arbiter side
    modport slave (
        input  read_I_L2, address_I_L2,
        output ready_L2_I, read_data_L2_I,
        input  read_D_L2, write_D_L2, address_D_L2, write_address_D_L2, write_data_D_L2,
        output ready_L2_D, read_data_L2_D,
        output read_L1_L2, write_L1_L2, address_L1_L2, write_address_L1_L2, write_data_L1_L2,
        input  read_data_L2_L1, ready_L2_L1
    );

    // Environment side: the two L1 controllers and the L2 controller
    modport master (
        output read_I_L2, address_I_L2,
        input  ready_L2_I, read_data_L2_I,
        output read_D_L2, write_D_L2, address_D_L2, write_address_D_L2, write_data_D_L2,
        input  ready_L2_D, read_data_L2_D,
        input  read_L1_L2, write_L1_L2, address_L1_L2, write_address_L1_L2, write_data_L1_L2,
        output read_data_L2_L1, ready_L2_L1
    );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant picker with last-grant memory
module rr_arb2
    import cache_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic req_d,
    input  logic update,
    output logic gnt,
    output logic valid
);
    logic last_grant;

    // Resetting to D hands the first tie to I
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GNT_D;
        end else if (update) begin
            last_grant <= gnt;
        end
    end

    always_comb begin
        valid = req_i | req_d;
        if (req_i && req_d) begin
            gnt = (last_grant == GNT_D) ? GNT_I : GNT_D;
        end else if (req_i) begin
            gnt = GNT_I;
        end else begin
            gnt = GNT_D;
        end
    end
endmodule

// File: rtl/l1_l2_arbiter.sv
// rtl/l1_l2_arbiter.sv - shares the L2 request port between L1 I and L1 D caches
module l1_l2_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LINE_W  = DEF_LINE_W,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    l1_l2_arbiter_if.slave   bus,
    output logic [CNT_W-1:0] cnt_grant_I,
    output logic [CNT_W-1:0] cnt_grant_D,
    output logic             timeout_err
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    arb_state_t        state_q;
    arb_state_t        next_state;
    logic              grant_en;
    logic              complete;
    logic              gnt;
    logic              gnt_valid;
    logic [WAIT_W-1:0] wait_cnt;

    logic              win_read;
    logic              win_write;
    logic [ADDR_W-1:0] win_addr;
    logic [ADDR_W-1:0] win_waddr;
    logic [LINE_W-1:0] win_wdata;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .req_i  (bus.read_I_L2),
        .req_d  (bus.read_D_L2 | bus.write_D_L2),
        .update (grant_en),
        .gnt    (gnt),
        .valid  (gnt_valid)
    );

    always_comb begin
        if (gnt == GNT_I) begin
            win_read  = bus.read_I_L2;
            win_write = 1'b0;
            win_addr  = bus.address_I_L2;
            win_waddr = '0;
            win_wdata = '0;
        end else begin
            win_read  = bus.read_D_L2;
            win_write = bus.write_D_L2;
            win_addr  = bus.address_D_L2;
            win_waddr = bus.write_address_D_L2;
            win_wdata = bus.write_data_D_L2;
        end
    end

    always_comb begin
        next_state = state_q;
        grant_en   = 1'b0;
        complete   = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    grant_en   = 1'b1;
                    next_state = (gnt == GNT_I) ? GRANT_I : GRANT_D;
                end
            end
            GRANT_I, GRANT_D: begin
                if (bus.ready_L2_L1) begin
                    complete   = 1'b1;
                    next_state = RELEASE;
                end
            end
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q                 <= IDLE;
            bus.read_L1_L2          <= 1'b0;
            bus.write_L1_L2         <= 1'b0;
            bus.address_L1_L2       <= '0;
            bus.write_address_L1_L2 <= '0;
            bus.write_data_L1_L2    <= '0;
            bus.ready_L2_I          <= 1'b0;
            bus.ready_L2_D          <= 1'b0;
            bus.read_data_L2_I      <= '0;
            bus.read_data_L2_D      <= '0;
            cnt_grant_I             <= '0;
            cnt_grant_D             <= '0;
            timeout_err             <= 1'b0;
            wait_cnt                <= '0;
        end else begin
            state_q        <= next_state;
            bus.ready_L2_I <= 1'b0;
            bus.ready_L2_D <= 1'b0;

            if (grant_en) begin
                bus.read_L1_L2          <= win_read;
                bus.write_L1_L2         <= win_write;
                bus.address_L1_L2       <= win_addr;
                bus.write_address_L1_L2 <= win_waddr;
                bus.write_data_L1_L2    <= win_wdata;
                wait_cnt                <= '0;
                if (gnt == GNT_I) begin
                    cnt_grant_I <= cnt_grant_I + CNT_W'(1);
                end else begin
                    cnt_grant_D <= cnt_grant_D + CNT_W'(1);
                end
            end

            if (state_q == GRANT_I || state_q == GRANT_D) begin
                // Saturate so a hung L2 cannot wrap the counter back below threshold
                if (wait_cnt != WAIT_W'(TIMEOUT)) begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                if (wait_cnt >= WAIT_W'(TIMEOUT - 1)) begin
                    timeout_err <= 1'b1;
                end
                if (complete) begin
                    bus.read_L1_L2  <= 1'b0;
                    bus.write_L1_L2 <= 1'b0;
                    if (state_q == GRANT_I) begin
                        bus.read_data_L2_I <= bus.read_data_L2_L1;
                        bus.ready_L2_I     <= 1'b1;
                    end else begin
                        bus.read_data_L2_D <= bus.read_data_L2_L1;
                        bus.ready_L2_D     <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_l1_l2_arbiter.sv
// tb/tb_l1_l2_arbiter.sv - directed self-checking bench for l1_l2_arbiter
module tb_l1_l2_arbiter;
    localparam int ADDR_W  = 26;
    localparam int LINE_W  = 512;
    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 16;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] cnt_grant_I;
    logic [CNT_W-1:0] cnt_grant_D;
    logic             timeout_err;
    int               total;
    int               bad;

    l1_l2_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bif ();

    l1_l2_arbiter #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bif),
        .cnt_grant_I (cnt_grant_I),
        .cnt_grant_D (cnt_grant_D),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bif.read_I_L2          = 1'b0;
        bif.address_I_L2       = '0;
        bif.read_D_L2          = 1'b0;
        bif.write_D_L2         = 1'b0;
        bif.address_D_L2       = '0;
        bif.write_address_D_L2 = '0;
        bif.write_data_D_L2    = '0;
        bif.read_data_L2_L1    = '0;
        bif.ready_L2_L1        = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // L2 model: idle for gap cycles, then a one-cycle ready with the given line
    task automatic l2_ack(input int gap, input logic [LINE_W-1:0] line);
        repeat (gap) tick();
        bif.ready_L2_L1     = 1'b1;
        bif.read_data_L2_L1 = line;
        tick();
        bif.ready_L2_L1     = 1'b0;
        bif.read_data_L2_L1 = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        total++; if (bif.read_L1_L2 !== 1'b0) begin bad++; $display("FAIL reset_read got=%b exp=0", bif.read_L1_L2); end
        total++; if (bif.write_L1_L2 !== 1'b0) begin bad++; $display("FAIL reset_write got=%b exp=0", bif.write_L1_L2); end
        total++; if (bif.address_L1_L2 !== '0) begin bad++; $display("FAIL reset_addr got=%h exp=0", bif.address_L1_L2); end
        total++; if (bif.ready_L2_I !== 1'b0 || bif.ready_L2_D !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b%b exp=00", bif.ready_L2_I, bif.ready_L2_D); end
        total++; if (cnt_grant_I !== '0 || cnt_grant_D !== '0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt_grant_I, cnt_grant_D); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout_err); end
        total++; if (bif.read_data_L2_I !== '0) begin bad++; $display("FAIL reset_rdata_i got=%h exp=0", bif.read_data_L2_I); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_i_only();
        logic [LINE_W-1:0] line_a5;
        line_a5 = {64{8'hA5}};
        bif.read_I_L2    = 1'b1;
        bif.address_I_L2 = 26'h0000040;
        tick();
        total++; if (bif.read_L1_L2 !== 1'b1) begin bad++; $display("FAIL i_only_read got=%b exp=1", bif.read_L1_L2); end
        total++; if (bif.write_L1_L2 !== 1'b0) begin bad++; $display("FAIL i_only_write got=%b exp=0", bif.write_L1_L2); end
        total++; if (bif.address_L1_L2 !== 26'h0000040) begin bad++; $display("FAIL i_only_addr got=%h exp=0000040", bif.address_L1_L2); end
        total++; if (cnt_grant_I !== 32'd1) begin bad++; $display("FAIL i_only_cnt got=%0d exp=1", cnt_grant_I); end
        l2_ack(2, line_a5);
        total++; if (bif.ready_L2_I !== 1'b1) begin bad++; $display("FAIL i_only_ready got=%b exp=1", bif.ready_L2_I); end
        total++; if (bif.read_data_L2_I !== line_a5) begin bad++; $display("FAIL i_only_line got=%h exp=%h", bif.read_data_L2_I, line_a5); end
        total++; if (bif.ready_L2_D !== 1'b0) begin bad++; $display("FAIL i_only_ready_d got=%b exp=0", bif.ready_L2_D); end
        total++; if (bif.read_L1_L2 !== 1'b0) begin bad++; $display("FAIL i_only_drop got=%b exp=0", bif.read_L1_L2); end
        bif.read_I_L2 = 1'b0;
        tick();
        total++; if (bif.ready_L2_I !== 1'b0) begin bad++; $display("FAIL i_only_pulse_len got=%b exp=0", bif.ready_L2_I); end
        total++; if (bif.read_data_L2_I !== line_a5) begin bad++; $display("FAIL i_only_hold got=%h exp=%h", bif.read_data_L2_I, line_a5); end
        tick();
    endtask

    task automatic test_both_same_cycle();
        do_reset();
        bif.read_I_L2    = 1'b1;
        bif.address_I_L2 = 26'h0000100;
        bif.read_D_L2    = 1'b1;
        bif.address_D_L2 = 26'h0000200;
        tick();
        total++; if (bif.address_L1_L2 !== 26'h0000100) begin bad++; $display("FAIL both_first got=%h exp=0000100", bif.address_L1_L2); end
        l2_ack(1, LINE_W'(512'h11));
        total++; if (bif.ready_L2_I !== 1'b1 || bif.ready_L2_D !== 1'b0) begin bad++; $display("FAIL both_ready_i got=%b%b exp=10", bif.ready_L2_I, bif.ready_L2_D); end
        bif.read_I_L2 = 1'b0;
        tick();
        total++; if (bif.read_L1_L2 !== 1'b0) begin bad++; $display("FAIL both_release got=%b exp=0", bif.read_L1_L2); end
        tick();
        total++; if (bif.read_L1_L2 !== 1'b1 || bif.address_L1_L2 !== 26'h0000200) begin bad++; $display("FAIL both_second got=%b/%h exp=1/0000200", bif.read_L1_L2, bif.address_L1_L2); end
        total++; if (cnt_grant_I !== 32'd1 || cnt_grant_D !== 32'd1) begin bad++; $display("FAIL both_cnt got=%0d/%0d exp=1/1", cnt_grant_I, cnt_grant_D); end
        l2_ack(1, LINE_W'(512'h22));
        total++; if (bif.ready_L2_D !== 1'b1 || bif.read_data_L2_D !== LINE_W'(512'h22)) begin bad++; $display("FAIL both_ready_d got=%b/%h exp=1/22", bif.ready_L2_D, bif.read_data_L2_D); end
        total++; if (bif.read_data_L2_I !== LINE_W'(512'h11)) begin bad++; $display("FAIL both_i_hold got=%h exp=11", bif.read_data_L2_I); end
        bif.read_D_L2 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_i;
        do_reset();
        bif.read_I_L2    = 1'b1;
        bif.address_I_L2 = 26'h0000111;
        bif.read_D_L2    = 1'b1;
        bif.address_D_L2 = 26'h0000222;
        tick();
        for (int k = 0; k < 6; k++) begin
            exp_i = (k % 2 == 0);
            total++; if (bif.address_L1_L2 !== (exp_i ? 26'h0000111 : 26'h0000222)) begin bad++; $display("FAIL alt_grant k=%0d got=%h exp_i=%b", k, bif.address_L1_L2, exp_i); end
            l2_ack(1, LINE_W'(k + 1));
            total++; if (bif.ready_L2_I !== exp_i || bif.ready_L2_D !== !exp_i) begin bad++; $display("FAIL alt_ready k=%0d got=%b%b exp_i=%b", k, bif.ready_L2_I, bif.ready_L2_D, exp_i); end
            if (k == 5) begin
                bif.read_I_L2 = 1'b0;
                bif.read_D_L2 = 1'b0;
            end
            tick();
            tick();
        end
        total++; if (cnt_grant_I !== 32'd3 || cnt_grant_D !== 32'd3) begin bad++; $display("FAIL alt_cnt got=%0d/%0d exp=3/3", cnt_grant_I, cnt_grant_D); end
        total++; if (bif.read_L1_L2 !== 1'b0) begin bad++; $display("FAIL alt_idle got=%b exp=0", bif.read_L1_L2); end
    endtask

    task automatic test_dirty_evict();
        int pulses;
        bif.read_D_L2          = 1'b1;
        bif.write_D_L2         = 1'b1;
        bif.address_D_L2       = 26'h1000040;
        bif.write_address_D_L2 = 26'h2000040;
        bif.write_data_D_L2    = LINE_W'(512'h1234);
        tick();
        total++; if (bif.read_L1_L2 !== 1'b1 || bif.write_L1_L2 !== 1'b1) begin bad++; $display("FAIL evict_rw got=%b%b exp=11", bif.read_L1_L2, bif.write_L1_L2); end
        total++; if (bif.address_L1_L2 !== 26'h1000040) begin bad++; $display("FAIL evict_raddr got=%h exp=1000040", bif.address_L1_L2); end
        total++; if (bif.write_address_L1_L2 !== 26'h2000040) begin bad++; $display("FAIL evict_waddr got=%h exp=2000040", bif.write_address_L1_L2); end
        total++; if (bif.write_data_L1_L2 !== LINE_W'(512'h1234)) begin bad++; $display("FAIL evict_wdata got=%h exp=1234", bif.write_data_L1_L2); end
        l2_ack(2, LINE_W'(512'h55));
        pulses = 0;
        if (bif.ready_L2_D === 1'b1) pulses++;
        bif.read_D_L2  = 1'b0;
        bif.write_D_L2 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bif.ready_L2_D === 1'b1) pulses++;
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL evict_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_timeout();
        do_reset();
        bif.read_I_L2    = 1'b1;
        bif.address_I_L2 = 26'h0000300;
        tick();
        repeat (TIMEOUT - 1) tick();
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b exp=0", timeout_err); end
        tick();
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_rise got=%b exp=1", timeout_err); end
        repeat (5) tick();
        total++; if (timeout_err !== 1'b1 || bif.read_L1_L2 !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b/%b exp=1/1", timeout_err, bif.read_L1_L2); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (bif.read_L1_L2 !== 1'b0 || bif.address_L1_L2 !== '0) begin bad++; $display("FAIL async_rst_req got=%b/%h exp=0/0", bif.read_L1_L2, bif.address_L1_L2); end
        total++; if (timeout_err !== 1'b0 || cnt_grant_I !== '0) begin bad++; $display("FAIL async_rst_state got=%b/%0d exp=0/0", timeout_err, cnt_grant_I); end
        clear_inputs();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_idle_ready();
        bif.ready_L2_L1     = 1'b1;
        bif.read_data_L2_L1 = {LINE_W{1'b1}};
        tick();
        bif.ready_L2_L1     = 1'b0;
        bif.read_data_L2_L1 = '0;
        total++; if (bif.ready_L2_I !== 1'b0 || bif.ready_L2_D !== 1'b0) begin bad++; $display("FAIL idle_ready got=%b%b exp=00", bif.ready_L2_I, bif.ready_L2_D); end
        total++; if (bif.read_data_L2_I !== '0 || bif.read_data_L2_D !== '0) begin bad++; $display("FAIL idle_rdata got=%h/%h exp=0/0", bif.read_data_L2_I, bif.read_data_L2_D); end
        tick();
        total++; if (bif.ready_L2_I !== 1'b0 || bif.read_L1_L2 !== 1'b0) begin bad++; $display("FAIL idle_quiet got=%b/%b exp=0/0", bif.ready_L2_I, bif.read_L1_L2); end
        bif.read_I_L2    = 1'b1;
        bif.address_I_L2 = 26'h0000400;
        tick();
        total++; if (bif.read_L1_L2 !== 1'b1 || bif.address_L1_L2 !== 26'h0000400) begin bad++; $display("FAIL idle_still_idle got=%b/%h exp=1/0000400", bif.read_L1_L2, bif.address_L1_L2); end
        l2_ack(0, LINE_W'(512'h77));
        bif.read_I_L2 = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clear_inputs();
        test_reset();
        test_i_only();
        test_both_same_cycle();
        test_back_to_back();
        test_dirty_evict();
        test_timeout();
        test_idle_ready();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
